// File: rtl/ball_motion_ctrl.sv
// Ball state owner for the pong datapath: offsets, velocity, scores and the
// serve/play/point/game-over sequence, advanced once per frame tick.
module ball_motion_ctrl #(
  parameter logic [31:0] BALL_SPEED_INI = 32'd2,
  parameter logic [31:0] BALL_SPEED_MAX = 32'd6,
  parameter logic [7:0]  POINT_DELAY    = 8'd60,
  parameter logic [3:0]  WIN_SCORE      = 4'd9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_serve,
  input  logic        i_new_game,
  input  logic [3:0]  i_ball_detect_edge,
  input  logic [7:0]  i_collision_detect,
  output logic [31:0] o_ball_off_x,
  output logic [31:0] o_ball_off_y,
  output logic [31:0] o_ball_vel_x,
  output logic [31:0] o_ball_vel_y,
  output logic [3:0]  o_score_l,
  output logic [3:0]  o_score_r,
  output logic [1:0]  o_game_state
);

  typedef enum logic [1:0] {
    StServe    = 2'd0,
    StPlay     = 2'd1,
    StPoint    = 2'd2,
    StGameOver = 2'd3
  } state_e;

  state_e      r_state;
  logic [31:0] r_off_x;
  logic [31:0] r_off_y;
  logic [31:0] r_speed_x;
  logic        r_dir_x;      // 1 = moving left
  logic        r_dir_y;      // 1 = moving up
  logic        r_serve_dir;  // dir_x applied at the next serve
  logic [3:0]  r_score_l;
  logic [3:0]  r_score_r;
  logic [7:0]  r_cnt;

  state_e      w_state_nxt;
  logic [31:0] w_off_x_nxt;
  logic [31:0] w_off_y_nxt;
  logic [31:0] w_speed_x_nxt;
  logic        w_dir_x_nxt;
  logic        w_dir_y_nxt;
  logic        w_serve_dir_nxt;
  logic [3:0]  w_score_l_nxt;
  logic [3:0]  w_score_r_nxt;
  logic [7:0]  w_cnt_nxt;

  logic        w_r_hit;
  logic        w_l_hit;
  logic        w_r_wall;
  logic        w_l_wall;
  logic        w_top;
  logic        w_bottom;
  logic [31:0] w_speed_inc;
  logic [31:0] w_vel_x_nxt;
  logic [31:0] w_vel_y_nxt;
  logic        w_unused_coll;

  assign w_unused_coll = ^{i_collision_detect[7:6], i_collision_detect[4:3]};

  // Flags only count when they agree with the direction of travel, so a ball still
  // overlapping a region after reflecting is not bounced twice.
  assign w_r_hit  = i_collision_detect[0] & i_collision_detect[2] & ~r_dir_x;
  assign w_l_hit  = i_collision_detect[1] & i_collision_detect[5] &  r_dir_x;
  assign w_r_wall = ~i_ball_detect_edge[1] & ~r_dir_x & ~w_r_hit;
  assign w_l_wall = ~i_ball_detect_edge[3] &  r_dir_x & ~w_l_hit;
  assign w_top    = ~i_ball_detect_edge[2] &  r_dir_y;
  assign w_bottom = ~i_ball_detect_edge[0] & ~r_dir_y;

  assign w_speed_inc = (r_speed_x >= BALL_SPEED_MAX) ? BALL_SPEED_MAX : r_speed_x + 32'd1;

  // Post-update velocity, so the ball moves away from a wall on the tick it reflects.
  assign w_vel_x_nxt = w_dir_x_nxt ? (32'd0 - w_speed_x_nxt) : w_speed_x_nxt;
  assign w_vel_y_nxt = w_dir_y_nxt ? (32'd0 - BALL_SPEED_INI) : BALL_SPEED_INI;

  always_comb begin
    w_state_nxt     = r_state;
    w_off_x_nxt     = r_off_x;
    w_off_y_nxt     = r_off_y;
    w_speed_x_nxt   = r_speed_x;
    w_dir_x_nxt     = r_dir_x;
    w_dir_y_nxt     = r_dir_y;
    w_serve_dir_nxt = r_serve_dir;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    w_cnt_nxt       = r_cnt;

    unique case (r_state)
      StServe: begin
        if (i_frame_tick && i_serve) begin
          w_state_nxt = StPlay;
        end
      end

      StPlay: begin
        if (i_frame_tick) begin
          if (w_top) begin
            w_dir_y_nxt = 1'b0;
          end else if (w_bottom) begin
            w_dir_y_nxt = 1'b1;
          end

          if (w_r_hit) begin
            w_dir_x_nxt   = 1'b1;
            w_speed_x_nxt = w_speed_inc;
          end else if (w_l_hit) begin
            w_dir_x_nxt   = 1'b0;
            w_speed_x_nxt = w_speed_inc;
          end else if (w_r_wall) begin
            if (r_score_l != WIN_SCORE) begin
              w_score_l_nxt = r_score_l + 4'd1;
            end
            w_serve_dir_nxt = 1'b0;
            w_state_nxt     = StPoint;
          end else if (w_l_wall) begin
            if (r_score_r != WIN_SCORE) begin
              w_score_r_nxt = r_score_r + 4'd1;
            end
            w_serve_dir_nxt = 1'b1;
            w_state_nxt     = StPoint;
          end

          if (!w_r_wall && !w_l_wall) begin
            w_off_x_nxt = r_off_x + w_vel_x_nxt;
            w_off_y_nxt = r_off_y + w_vel_y_nxt;
          end
        end
      end

      StPoint: begin
        if (i_frame_tick) begin
          if (r_cnt == POINT_DELAY - 8'd1) begin
            w_off_x_nxt   = 32'd0;
            w_off_y_nxt   = 32'd0;
            w_speed_x_nxt = BALL_SPEED_INI;
            w_dir_x_nxt   = r_serve_dir;
            w_dir_y_nxt   = 1'b0;
            w_cnt_nxt     = 8'd0;
            if (r_score_l == WIN_SCORE || r_score_r == WIN_SCORE) begin
              w_state_nxt = StGameOver;
            end else begin
              w_state_nxt = StServe;
            end
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end

      StGameOver: begin
        if (i_new_game) begin
          w_score_l_nxt   = 4'd0;
          w_score_r_nxt   = 4'd0;
          w_off_x_nxt     = 32'd0;
          w_off_y_nxt     = 32'd0;
          w_speed_x_nxt   = BALL_SPEED_INI;
          w_dir_x_nxt     = 1'b0;
          w_dir_y_nxt     = 1'b0;
          w_serve_dir_nxt = 1'b0;
          w_cnt_nxt       = 8'd0;
          w_state_nxt     = StServe;
        end
      end

      default: begin
        w_state_nxt = StServe;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StServe;
      r_off_x     <= 32'd0;
      r_off_y     <= 32'd0;
      r_speed_x   <= BALL_SPEED_INI;
      r_dir_x     <= 1'b0;
      r_dir_y     <= 1'b0;
      r_serve_dir <= 1'b0;
      r_score_l   <= 4'd0;
      r_score_r   <= 4'd0;
      r_cnt       <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_off_x     <= w_off_x_nxt;
      r_off_y     <= w_off_y_nxt;
      r_speed_x   <= w_speed_x_nxt;
      r_dir_x     <= w_dir_x_nxt;
      r_dir_y     <= w_dir_y_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign o_ball_off_x  = r_off_x;
  assign o_ball_off_y  = r_off_y;
  assign o_ball_vel_x  = r_dir_x ? (32'd0 - r_speed_x) : r_speed_x;
  assign o_ball_vel_y  = r_dir_y ? (32'd0 - BALL_SPEED_INI) : BALL_SPEED_INI;
  assign o_score_l     = r_score_l;
  assign o_score_r     = r_score_r;
  assign o_game_state  = r_state;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: stimulus pushes expected snapshots into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ball_motion_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        serve;
  logic        new_game;
  logic [3:0]  edge_n;
  logic [7:0]  coll;
  logic [31:0] off_x;
  logic [31:0] off_y;
  logic [31:0] vel_x;
  logic [31:0] vel_y;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic [1:0]  game_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] ox;
    logic [31:0] oy;
    logic [31:0] vx;
    logic [31:0] vy;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ball_motion_ctrl dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_frame_tick       (frame_tick),
    .i_serve            (serve),
    .i_new_game         (new_game),
    .i_ball_detect_edge (edge_n),
    .i_collision_detect (coll),
    .o_ball_off_x       (off_x),
    .o_ball_off_y       (off_y),
    .o_ball_vel_x       (vel_x),
    .o_ball_vel_y       (vel_y),
    .o_score_l          (score_l),
    .o_score_r          (score_r),
    .o_game_state       (game_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if (off_x !== mon_e.ox || off_y !== mon_e.oy || vel_x !== mon_e.vx ||
          vel_y !== mon_e.vy || score_l !== mon_e.sl || score_r !== mon_e.sr ||
          game_state !== mon_e.st) begin
        bad++;
        $display("FAIL %s: got off=%0d/%0d vel=%0d/%0d score=%0d/%0d st=%0d, want off=%0d/%0d vel=%0d/%0d score=%0d/%0d st=%0d",
                 mon_e.name, $signed(off_x), $signed(off_y), $signed(vel_x), $signed(vel_y),
                 score_l, score_r, game_state, $signed(mon_e.ox), $signed(mon_e.oy),
                 $signed(mon_e.vx), $signed(mon_e.vy), mon_e.sl, mon_e.sr, mon_e.st);
      end
    end
  end

  task automatic expect_st(input string name, input int ox, input int oy, input int vx,
                           input int vy, input int sl, input int sr, input int st);
    exp_t e;
    e.name = name;
    e.ox   = ox;
    e.oy   = oy;
    e.vx   = vx;
    e.vy   = vy;
    e.sl   = 4'(sl);
    e.sr   = 4'(sr);
    e.st   = 2'(st);
    exp_q.push_back(e);
  endtask

  // One clock with the given inputs; pulses and flags drop again just after the edge.
  task automatic step(input logic tk, input logic sv, input logic ng, input logic [3:0] ed,
                      input logic [7:0] cd);
    frame_tick = tk;
    serve      = sv;
    new_game   = ng;
    edge_n     = ed;
    coll       = cd;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    serve      = 1'b0;
    new_game   = 1'b0;
    edge_n     = 4'hF;
    coll       = 8'h00;
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'h00);
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    serve      = 1'b0;
    new_game   = 1'b0;
    edge_n     = 4'hF;
    coll       = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_st("reset", 0, 0, 2, 2, 0, 0, 0);

    tick();
    expect_st("tick_no_serve", 0, 0, 2, 2, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 4'hF, 8'h00);
    expect_st("serve_no_tick", 0, 0, 2, 2, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 4'hF, 8'h00);
    expect_st("serve", 0, 0, 2, 2, 0, 0, 1);

    tick();
    expect_st("flight1", 2, 2, 2, 2, 0, 0, 1);
    tick();
    tick();
    expect_st("flight3", 6, 6, 2, 2, 0, 0, 1);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 8'b0000_0101);
    expect_st("no_tick_flags", 6, 6, 2, 2, 0, 0, 1);

    step(1'b1, 1'b0, 1'b0, 4'b1110, 8'h00);
    expect_st("bottom_wall", 8, 4, 2, -2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'b1011, 8'h00);
    expect_st("top_wall", 10, 6, 2, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'b1011, 8'h00);
    expect_st("top_hold1", 12, 8, 2, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'b1011, 8'h00);
    expect_st("top_hold2", 14, 10, 2, 2, 0, 0, 1);

    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0000_0101);
    expect_st("r_hit", 11, 12, -3, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0000_0101);
    expect_st("r_hit_moving_left", 8, 14, -3, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0010_0010);
    expect_st("l_hit", 12, 16, 4, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0000_0101);
    expect_st("r_hit2", 7, 18, -5, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0010_0010);
    expect_st("l_hit2", 13, 20, 6, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0000_0101);
    expect_st("r_hit_speed_max", 7, 22, -6, 2, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 4'b1101, 8'h00);
    expect_st("r_wall_moving_left", 1, 24, -6, 2, 0, 0, 1);

    step(1'b1, 1'b0, 1'b0, 4'b0111, 8'h00);
    expect_st("l_miss", 1, 24, -6, 2, 0, 1, 2);
    repeat (30) tick();
    step(1'b0, 1'b0, 1'b0, 4'hF, 8'h00);
    repeat (29) tick();
    expect_st("point_hold", 1, 24, -6, 2, 0, 1, 2);
    tick();
    expect_st("point_end_left", 0, 0, -2, 2, 0, 1, 0);

    step(1'b1, 1'b1, 1'b0, 4'hF, 8'h00);
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0010_0010);
    expect_st("l_hit_after_serve", 3, 2, 3, 2, 0, 1, 1);
    step(1'b1, 1'b0, 1'b0, 4'b1101, 8'h00);
    expect_st("r_miss", 3, 2, 3, 2, 1, 1, 2);
    repeat (60) tick();
    expect_st("point_end_right", 0, 0, 2, 2, 1, 1, 0);

    for (int i = 2; i <= 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'hF, 8'h00);
      step(1'b1, 1'b0, 1'b0, 4'b1101, 8'h00);
      expect_st($sformatf("miss_%0d", i), 0, 0, 2, 2, i, 1, 2);
      repeat (60) tick();
      expect_st($sformatf("after_point_%0d", i), 0, 0, 2, 2, i, 1, (i == 9) ? 3 : 0);
    end

    step(1'b1, 1'b1, 1'b0, 4'b0000, 8'hFF);
    expect_st("game_over_hold", 0, 0, 2, 2, 9, 1, 3);
    step(1'b0, 1'b0, 1'b1, 4'hF, 8'h00);
    expect_st("new_game", 0, 0, 2, 2, 0, 0, 0);

    step(1'b1, 1'b1, 1'b0, 4'hF, 8'h00);
    tick();
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0000_0101);
    expect_st("pre_rst", -1, 4, -3, 2, 0, 0, 1);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 4'hF, 8'b0000_0101);
    rst = 1'b0;
    expect_st("mid_play_rst", 0, 0, 2, 2, 0, 0, 0);

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
